// File: rtl/chopper_phase_gen.sv
// ---------------------------------------------------------------------------
// chopper_phase_gen
//
// Generates non-overlapping chopping phases (phi_a / phi_b) for NCH chopper
// channels of the chopped bandgap macro. It also produces a demodulation
// sample strobe, which is suppressed for the first BLANK full chop periods
// after start-up.
//
// Phase sequence in free-run:
//   A_ON (div+1) -> DEAD_AB (dead) -> B_ON (div+1) -> DEAD_BA (dead) -> A_ON
// A full period is therefore 2*(div+1+dead) clock cycles.
//
// Parameters:
//   DIV_W  - width of div; an ON phase lasts div+1 clk cycles
//   DEAD_W - width of dead; a dead time lasts dead clk cycles (0 allowed)
//   NCH    - number of chopper channels (>= 1)
//   BLANK  - full chop periods after start with sample_stb suppressed
//
// Ports:
//   clk        - system clock
//   rst        - synchronous, active-high reset
//   en         - run enable; low stops at once
//   mode       - 00 free-run, 01 hold A, 10 hold B, 11 off
//   div        - ON half-period minus 1 (sampled when an ON phase loads)
//   dead       - dead-time cycles (sampled when a dead phase loads)
//   ch_en      - per-channel output enable
//   phi_a      - phase A drive per channel (registered)
//   phi_b      - phase B drive per channel (registered)
//   chop_sign  - 1 while the last ON phase was A, 0 for B (registered)
//   sample_stb - one-cycle demod sample pulse on the last ON cycle
//   busy       - high whenever the generator is not idle (registered)
// ---------------------------------------------------------------------------
module chopper_phase_gen #(
  parameter int DIV_W  = 8,
  parameter int DEAD_W = 4,
  parameter int NCH    = 2,
  parameter int BLANK  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [DEAD_W-1:0] dead,
  input  logic [NCH-1:0]    ch_en,
  output logic [NCH-1:0]    phi_a,
  output logic [NCH-1:0]    phi_b,
  output logic              chop_sign,
  output logic              sample_stb,
  output logic              busy
);

  // One down-counter serves both ON and dead phases, so it must hold either.
  localparam int CNT_W = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;
  localparam int BLK_W = (BLANK < 1) ? 1 : $clog2(BLANK + 1);
  localparam logic [BLK_W-1:0] BLANK_V = BLK_W'(BLANK);

  localparam logic [1:0] MODE_FREE   = 2'b00;
  localparam logic [1:0] MODE_HOLD_A = 2'b01;
  localparam logic [1:0] MODE_HOLD_B = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_ON,
    ST_DEAD_AB,
    ST_B_ON,
    ST_DEAD_BA
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]   blank_q, blank_d;
  logic               sign_q, sign_d;
  logic [1:0]         end_mode_q, end_mode_d;
  logic [NCH-1:0]     phi_a_q, phi_a_d;
  logic [NCH-1:0]     phi_b_q, phi_b_d;
  logic               stb_q, stb_d;
  logic               busy_q, busy_d;

  logic               stop;
  logic               last_d;
  logic [CNT_W-1:0]   div_ld;
  logic [CNT_W-1:0]   dead_ld;

  assign stop    = !en || (mode == MODE_OFF);
  assign div_ld  = CNT_W'(div);
  // Only used when dead is nonzero, so the subtraction never wraps.
  assign dead_ld = CNT_W'(dead - DEAD_W'(1));

  // Next-state logic. Dropping both phases never creates overlap, so a stop
  // request (en low or mode off) overrides everything and returns to IDLE.
  // The hold/advance decision at the end of an ON phase uses end_mode_q,
  // the mode captured on entry to that phase's final cycle. The strobe is
  // decided from the same sample, so a strobe always lands on a cycle that
  // really is the last one of its phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blank_d    = blank_q;
    sign_d     = sign_q;
    end_mode_d = end_mode_q;

    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sign_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          blank_d = '0;
          cnt_d   = div_ld;
          if (mode == MODE_HOLD_B) begin
            state_d = ST_B_ON;
            sign_d  = 1'b0;
          end else begin
            state_d = ST_A_ON;
            sign_d  = 1'b1;
          end
        end

        ST_A_ON: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (end_mode_q == MODE_HOLD_A) begin
            cnt_d = div_ld;
          end else if (dead == '0) begin
            state_d = ST_B_ON;
            cnt_d   = div_ld;
            sign_d  = 1'b0;
          end else begin
            state_d = ST_DEAD_AB;
            cnt_d   = dead_ld;
          end
        end

        ST_DEAD_AB: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = ST_B_ON;
            cnt_d   = div_ld;
            sign_d  = 1'b0;
          end
        end

        ST_B_ON: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (end_mode_q == MODE_HOLD_B) begin
            cnt_d = div_ld;
          end else begin
            // A completed B phase closes one full chop period.
            if (blank_q != BLANK_V) begin
              blank_d = blank_q + BLK_W'(1);
            end
            if (dead == '0) begin
              state_d = ST_A_ON;
              cnt_d   = div_ld;
              sign_d  = 1'b1;
            end else begin
              state_d = ST_DEAD_BA;
              cnt_d   = dead_ld;
            end
          end
        end

        ST_DEAD_BA: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = ST_A_ON;
            cnt_d   = div_ld;
            sign_d  = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sign_d  = 1'b0;
        end
      endcase
    end

    last_d = ((state_d == ST_A_ON) || (state_d == ST_B_ON)) && (cnt_d == '0);
    if (last_d) begin
      end_mode_d = mode;
    end

    // The blank counter saturates at BLANK, so equality means "blanking done".
    stb_d   = last_d && (mode == MODE_FREE) && (blank_d == BLANK_V);
    phi_a_d = ch_en & {NCH{state_d == ST_A_ON}};
    phi_b_d = ch_en & {NCH{state_d == ST_B_ON}};
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers. Every pin comes straight from a flop so the
  // analog switch drivers never see decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      blank_q    <= '0;
      sign_q     <= 1'b0;
      end_mode_q <= MODE_FREE;
      phi_a_q    <= '0;
      phi_b_q    <= '0;
      stb_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      sign_q     <= sign_d;
      end_mode_q <= end_mode_d;
      phi_a_q    <= phi_a_d;
      phi_b_q    <= phi_b_d;
      stb_q      <= stb_d;
      busy_q     <= busy_d;
    end
  end

  assign phi_a      = phi_a_q;
  assign phi_b      = phi_b_q;
  assign chop_sign  = sign_q;
  assign sample_stb = stb_q;
  assign busy       = busy_q;

endmodule

// File: doc/chopper_phase_gen.md
Name: chopper_phase_gen

Overview:
- Parametrised, digitally controlled chopping-phase generator for the chopped bandgap macro.
- Produces non-overlapping chop phases phi_a/phi_b for NCH chopper channels from the system clock.
- Features: programmable half-period, programmable dead time, hold/off modes, and a demodulation sample strobe with start-up blanking.
- Sits between the tile's digital inputs and the analog chopper switch drivers.

Parameters:
- DIV_W, 8: width of div; ON phase length = div+1 clk cycles.
- DEAD_W, 4: width of dead; dead time = dead clk cycles (0 allowed).
- NCH, 2: number of chopper channels (≥1).
- BLANK, 2: full chop periods after start during which sample_stb is suppressed (0 = no blanking).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- mode  in  2  00 free-run, 01 hold A, 10 hold B, 11 off.
- div  in  DIV_W  ON half-period minus 1.
- dead  in  DEAD_W  dead-time cycles.
- ch_en  in  NCH  per-channel output enable.
- phi_a  out  NCH  phase A drive per channel.
- phi_b  out  NCH  phase B drive per channel.
- chop_sign  out  1  1 while last ON phase was A, 0 for B.
- sample_stb  out  1  one-cycle demod sample pulse.
- busy  out  1  state != IDLE.

Behaviour:
- One clock: clk. Reset: rst, synchronous, active-high.
- Reset values: state IDLE; phi_a=0, phi_b=0, chop_sign=0, sample_stb=0, busy=0; counters 0; blank count 0.
- All outputs are flops; no combinational decode to pins.
- Channel gating: phi_a[k] = ch_en[k] & A_ON; phi_b[k] = ch_en[k] & B_ON. A disabled channel holds both low.
- States: IDLE, A_ON, DEAD_AB, B_ON, DEAD_BA.
- IDLE, en=1 and mode!=11:
  - Next state is A_ON, or B_ON if mode=10.
  - No dead time on entry, since both phases are already low.
  - Clears the blank counter.
- Counter load: a down-counter loads div on entry to an ON state and dead-1 on entry to a DEAD state. div/dead are sampled only at load, so mid-phase changes apply at the next state.
- A_ON lasts div+1 cycles. At its last cycle (cnt=0):
  - mode=01: reload, stay A_ON, no strobe.
  - otherwise: go to DEAD_AB, or straight to B_ON if dead=0.
- DEAD_AB lasts dead cycles, then B_ON.
- B_ON and DEAD_BA are symmetric: mode=10 holds B_ON; otherwise go to DEAD_BA or A_ON.
- chop_sign updates on entry to an ON state (1 for A, 0 for B) and holds through dead time.
- sample_stb:
  - High on the last cycle of an ON phase only when mode=00 and blank_cnt ≥ BLANK.
  - Registered: asserted in the same cycle as cnt=0 of that phase.
- Blank counter: increments at each completed B_ON end and saturates at BLANK.
- Stop (en=0 or mode=11 sampled in any state):
  - Next cycle: state IDLE, phi_a=phi_b=0, sample_stb=0.
  - Immediate, because dropping a phase never creates overlap.
- Mode change mid-phase: evaluated only at ON-phase end, except 11, which acts immediately.
- Non-overlap invariant: phi_a & phi_b == 0 on every cycle for every channel, including across all mode, en and ch_en changes.
- Full period in free-run: 2*(div+1+dead) cycles.
- Reset mid-operation: all outputs low on the cycle after rst is sampled high; restart goes through IDLE.
- ch_en changes apply on the next cycle. Masking may shorten a phase pulse but never causes overlap.
- Counter widths: no wrap — the counter is only decremented while nonzero. div=0 gives 1-cycle ON phases.

Test Plan:
- Free-run, div=3, dead=1, BLANK=0, ch_en=2'b11, en↑ → phi_a high 4 cycles, both low 1, phi_b high 4, both low 1; period 10; sample_stb on 4th cycle of each ON; chop_sign toggles 1/0.
- Blanking, BLANK=2, div=1, dead=0 → no sample_stb during first 2 full periods (8 cycles); strobes begin in the 3rd period on every ON end.
- Hold: mode=01 written mid-B_ON → B completes, dead, then phi_a stays high indefinitely with no strobes. mode=00 → A ends at its next cnt=0 and chopping resumes.
- Stop/reset: mode=11 mid-A_ON → next cycle all outputs 0, busy=0. Repeat with rst=1 mid-DEAD_BA → all outputs reset values next cycle.
- Config update: change div 3→7 mid-A_ON → current A still 4 cycles, following B_ON 8 cycles. dead=0 → no both-low gap.
- Random mode/en/ch_en/div/dead stimulus for 10k cycles → assertion phi_a & phi_b == 0 always; each sample_stb coincides with the final cycle of an ON phase.
